// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum_accumulator block.
// Holds the FSM state encoding and the width of one adder beat ({c_out, s[3:0]}).
package sum_acc_pkg;

   // Control states of the burst accumulator
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One incoming beat is {carry-out, 4-bit sum}: values 0..31
   localparam int OPND_W = 5;

endpackage : sum_acc_pkg

// File: rtl/sum_accumulator_acc_adder.sv
// Ripple-carry adder used by sum_accumulator to add each beat into the running total.
// full_adder is the one-bit cell; acc_adder chains WIDTH of them, and its c_out is
// the carry out of the top bit, which the accumulator treats as overflow.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   // Single-bit sum and carry
   always_comb begin
      s     = a ^ b ^ c_in;
      c_out = (a & b) | (a & c_in) | (b & c_in);
   end

endmodule : full_adder

module acc_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   // carry[i] feeds bit i; carry[WIDTH] leaves the top bit
   logic [WIDTH:0] carry;

   assign carry[0] = c_in;
   assign c_out    = carry[WIDTH];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         full_adder u_fa (
            .a     (a[gi]),
            .b     (b[gi]),
            .c_in  (carry[gi]),
            .s     (s[gi]),
            .c_out (carry[gi+1])
         );
      end
   endgenerate

endmodule : acc_adder

// File: rtl/sum_accumulator.sv
// sum_accumulator: collects a burst of COUNT_MAX {c_out, sum} beats from the 4-bit
// adder into an ACC_W-bit total, then pulses done for one cycle.
// Build option SUM_ACC_SAT_EN: when defined, acc saturates to all-ones on overflow
// for the remainder of the burst; otherwise acc wraps modulo 2^ACC_W.
// overflow is sticky per burst in both builds.
// All outputs come from registers or from the state register alone.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int ACC_W     = 8,
   parameter int COUNT_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_sum,
   input  logic             in_cout,
   output logic [ACC_W-1:0] acc,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(COUNT_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT_MAX - 1);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  count;
   logic [ACC_W-1:0]  operand;
   logic [ACC_W-1:0]  sum_next;
   logic              carry_out;
   logic              beat;

   // Zero-extend the 5-bit beat to the accumulator width
   assign operand = {{(ACC_W - OPND_W){1'b0}}, in_cout, in_sum};
   assign beat    = in_valid && in_ready;

   acc_adder #(
      .WIDTH (ACC_W)
   ) u_adder (
      .a     (acc),
      .b     (operand),
      .c_in  (1'b0),
      .s     (sum_next),
      .c_out (carry_out)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start only matters in IDLE, beats only in ACCUM
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ACCUM;
         ACCUM:   if (beat && (count == LAST_BEAT)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: clear on an accepted start, add each accepted beat, hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else if (beat) begin
            count    <= count + CNT_W'(1);
            overflow <= overflow | carry_out;
`ifdef SUM_ACC_SAT_EN
            acc      <= (overflow | carry_out) ? '1 : sum_next;
`else
            acc      <= sum_next;
`endif
         end
      end
   end

endmodule : sum_accumulator
